// File: rtl/place_sched_pkg.sv
// place_sched_pkg
// Shared widths and the result-tag type for the placement request scheduler.
//   HEIGHT_W/WIDTH_W : rectangle size field widths
//   IDX_W            : placement index width returned by the engine
//   STRIKE_W         : engine strike counter width
//   MAX_REQ          : largest supported requester count
//   tag_t            : {valid, drop, id} carried alongside each issued request
package place_sched_pkg;

   localparam int HEIGHT_W = 5;
   localparam int WIDTH_W  = 5;
   localparam int IDX_W    = 8;
   localparam int STRIKE_W = 4;
   localparam int MAX_REQ  = 8;
   localparam int ID_W     = $clog2(MAX_REQ);

   typedef struct packed {
      logic            valid;
      logic            drop;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/place_sched_rr_arb.sv
// place_sched_rr_arb
// Round-robin arbiter: combinational grant of the first requesting client at
// or above the pointer (wrapping upward), plus the registered pointer, which
// moves past the winner only when the grant is actually taken.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   req           : per-client request lines
//   advance       : grant is consumed on this edge (slot start, not halted)
//   grant         : one-hot grant
//   grant_id      : binary index of the granted client
//   grant_valid   : some client is granted
module place_sched_rr_arb
   import place_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_valid
);

   logic [ID_W-1:0] ptr;

   always_comb begin
      int idx;
      grant_id    = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_valid && (|(req & (NUM_REQ'(1) << idx)))) begin
            grant_valid = 1'b1;
            grant_id    = ID_W'(idx);
         end
      end
      grant = grant_valid ? (NUM_REQ'(1) << grant_id) : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr <= '0;
      end else if (advance && grant_valid) begin
         ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/place_req_scheduler.sv
// place_req_scheduler
// Front end for the strip-placement engine. Arbitrates NUM_REQ clients
// round-robin, issues at most one rectangle per SLOT_CYCLES-clock slot, and
// routes each engine result back to its owner RESULT_LATENCY+1 clocks after
// the accept edge.
// Ports:
//   clk_i, rst_ni                  : clock, async active-low reset
//   req_valid_i/height_i/width_i   : client requests (5-bit fields packed per client)
//   req_ready_o                    : one-hot accept, high only before a slot start
//   eng_height_o/eng_width_o       : registered engine inputs, held for a slot
//   eng_index_x_i/y_i, eng_strike_i: engine results
//   rsp_valid_o/rsp_drop_o         : one-hot response pulse, drop qualifier
//   rsp_index_x_o/y_o              : returned placement, held until next response
//   strike_o                       : registered engine strike count
//   busy_o                         : some request in flight
//   halted_o                       : issuing stopped on strike limit
// Build option: define PLACE_SCHED_STRIKE_LIMIT_EN to stop issuing once
// strike_o reaches STRIKE_LIMIT; otherwise halted_o is tied low.
module place_req_scheduler
   import place_sched_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int SLOT_CYCLES    = 4,
   parameter int RESULT_LATENCY = 8,
   parameter int STRIKE_LIMIT   = 15
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [HEIGHT_W*NUM_REQ-1:0] req_height_i,
   input  logic [WIDTH_W*NUM_REQ-1:0]  req_width_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic [HEIGHT_W-1:0]         eng_height_o,
   output logic [WIDTH_W-1:0]          eng_width_o,
   input  logic [IDX_W-1:0]            eng_index_x_i,
   input  logic [IDX_W-1:0]            eng_index_y_i,
   input  logic [STRIKE_W-1:0]         eng_strike_i,
   output logic [NUM_REQ-1:0]          rsp_valid_o,
   output logic                        rsp_drop_o,
   output logic [IDX_W-1:0]            rsp_index_x_o,
   output logic [IDX_W-1:0]            rsp_index_y_o,
   output logic [STRIKE_W-1:0]         strike_o,
   output logic                        busy_o,
   output logic                        halted_o
);

   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   logic [CNT_W-1:0]    slot_cnt;
   logic                slot_start;
   logic                issue_en;
   logic                halted;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_id;
   logic                grant_valid;
   logic [HEIGHT_W-1:0] sel_height;
   logic [WIDTH_W-1:0]  sel_width;
   logic                zero_size;
   tag_t                new_tag;
   tag_t                out_tag;
   tag_t                tags [RESULT_LATENCY+1];

   assign slot_start = (slot_cnt == '0);
   assign issue_en   = slot_start && !halted;

   place_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req         (req_valid_i),
      .advance     (issue_en),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   // Slot counter idles at 0 in reset, so the raw grant would otherwise leak out.
   assign req_ready_o = (issue_en && rst_ni) ? grant : '0;

   assign sel_height = HEIGHT_W'(req_height_i >> (int'(grant_id) * HEIGHT_W));
   assign sel_width  = WIDTH_W'(req_width_i >> (int'(grant_id) * WIDTH_W));
   assign zero_size  = (sel_height == '0) || (sel_width == '0);

   always_comb begin
      new_tag       = '0;
      new_tag.valid = issue_en && grant_valid;
      new_tag.drop  = zero_size;
      new_tag.id    = grant_id;
   end

   assign out_tag = tags[RESULT_LATENCY];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_cnt <= '0;
      end else if (int'(slot_cnt) == SLOT_CYCLES - 1) begin
         slot_cnt <= '0;
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
      end
   end

   // Engine inputs change only at slot starts; drops, bubbles and halted slots
   // all present 0/0 so the engine never sees a stale rectangle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         eng_height_o <= '0;
         eng_width_o  <= '0;
      end else if (slot_start) begin
         if (issue_en && grant_valid && !zero_size) begin
            eng_height_o <= sel_height;
            eng_width_o  <= sel_width;
         end else begin
            eng_height_o <= '0;
            eng_width_o  <= '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i <= RESULT_LATENCY; i++) tags[i] <= '0;
      end else begin
         tags[0] <= new_tag.valid ? new_tag : '0;
         for (int i = 1; i <= RESULT_LATENCY; i++) tags[i] <= tags[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_o   <= '0;
         rsp_drop_o    <= 1'b0;
         rsp_index_x_o <= '0;
         rsp_index_y_o <= '0;
         strike_o      <= '0;
      end else begin
         rsp_valid_o <= out_tag.valid ? (NUM_REQ'(1) << out_tag.id) : '0;
         rsp_drop_o  <= out_tag.valid && out_tag.drop;
         if (out_tag.valid) begin
            rsp_index_x_o <= out_tag.drop ? '0 : eng_index_x_i;
            rsp_index_y_o <= out_tag.drop ? '0 : eng_index_y_i;
         end
         strike_o <= eng_strike_i;
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i <= RESULT_LATENCY; i++) busy_o = busy_o | tags[i].valid;
   end

`ifdef PLACE_SCHED_STRIKE_LIMIT_EN
   // Sticky until reset; tags already in the delay line still drain normally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         halted_o <= 1'b0;
      end else if (int'(strike_o) >= STRIKE_LIMIT) begin
         halted_o <= 1'b1;
      end
   end
`else
   assign halted_o = 1'b0;
`endif

   assign halted = halted_o;

endmodule

// File: tb/tb_place_req_scheduler.sv
module tb_place_req_scheduler;

   localparam int N     = 4;
   localparam int SLOT  = 4;
   localparam int LAT   = 8;
   localparam int LIMIT = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [5*N-1:0] req_height = '0;
   logic [5*N-1:0] req_width = '0;
   logic [N-1:0]  req_ready;
   logic [4:0]    eng_height, eng_width;
   logic [7:0]    eng_x = '0, eng_y = '0;
   logic [3:0]    eng_strike = '0;
   logic [N-1:0]  rsp_valid;
   logic          rsp_drop;
   logic [7:0]    rsp_x, rsp_y;
   logic [3:0]    strike;
   logic          busy, halted;

   always #5 clk = ~clk;

   place_req_scheduler #(.NUM_REQ(N), .SLOT_CYCLES(SLOT), .RESULT_LATENCY(LAT),
                         .STRIKE_LIMIT(LIMIT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_height_i(req_height), .req_width_i(req_width),
      .req_ready_o(req_ready),
      .eng_height_o(eng_height), .eng_width_o(eng_width),
      .eng_index_x_i(eng_x), .eng_index_y_i(eng_y), .eng_strike_i(eng_strike),
      .rsp_valid_o(rsp_valid), .rsp_drop_o(rsp_drop),
      .rsp_index_x_o(rsp_x), .rsp_index_y_o(rsp_y),
      .strike_o(strike), .busy_o(busy), .halted_o(halted)
   );

   int tests = 0;
   int errors = 0;
   int edge_no = 0;

   typedef struct {
      int id;
      bit drop;
      int x;
      int y;
      int due;
   } exp_t;
   exp_t q[$];

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stand-in engine: placement is a fixed function of the size it was given.
   function automatic logic [7:0] fx(input int h, input int w);
      return 8'((h * 7 + w) & 255);
   endfunction
   function automatic logic [7:0] fy(input int h, input int w);
      return 8'((w * 7 + h + 3) & 255);
   endfunction

   // Engine model: output reflects its inputs from LAT edges earlier.
   logic [9:0] eng_hist[$];
   logic [9:0] eng_v;
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         eng_hist.delete();
         eng_x = '0;
         eng_y = '0;
      end else begin
         eng_hist.push_back({eng_height, eng_width});
         if (eng_hist.size() > LAT) begin
            eng_v = eng_hist.pop_front();
            eng_x = fx(int'(eng_v[9:5]), int'(eng_v[4:0]));
            eng_y = fy(int'(eng_v[9:5]), int'(eng_v[4:0]));
         end
      end
   end

   // Reference model: slot position, RR pointer, halt flag, expected engine inputs.
   int         m_cnt, m_ptr, m_g, m_c, m_h, m_w;
   bit         m_halted, m_drop, rst_checked;
   logic [3:0] m_strike;
   int         m_eng_h, m_eng_w;
   exp_t       m_e;

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         q.delete();
         m_cnt = 0; m_ptr = 0; m_halted = 0; m_strike = '0;
         m_eng_h = 0; m_eng_w = 0; edge_no = 0;
         if (!rst_checked) begin
            rst_checked = 1;
            check("rst_ready", req_ready, 0);
            check("rst_eng_h", eng_height, 0);
            check("rst_eng_w", eng_width, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_x", rsp_x, 0);
            check("rst_busy", busy, 0);
            check("rst_halted", halted, 0);
            check("rst_strike", strike, 0);
         end
      end else begin
         rst_checked = 0;
         check("eng_height", eng_height, m_eng_h);
         check("eng_width", eng_width, m_eng_w);
         check("strike", strike, m_strike);
         check("halted", halted, m_halted);
         check("busy", busy, q.size() != 0);
         m_g = -1;
         if (m_cnt == 0 && !m_halted) begin
            for (int k = 0; k < N; k++) begin
               m_c = (m_ptr + k) % N;
               if (m_g < 0 && req_valid[m_c]) m_g = m_c;
            end
         end
         if (m_cnt == 0 || req_ready != 0)
            check("req_ready", req_ready, (m_g >= 0) ? (1 << m_g) : 0);
         edge_no++;
         if (m_cnt == 0) begin
            m_eng_h = 0;
            m_eng_w = 0;
            if (m_g >= 0) begin
               m_h = int'((req_height >> (5 * m_g)) & 31);
               m_w = int'((req_width >> (5 * m_g)) & 31);
               m_drop = (m_h == 0) || (m_w == 0);
               m_e.id = m_g;
               m_e.drop = m_drop;
               m_e.x = m_drop ? 0 : int'(fx(m_h, m_w));
               m_e.y = m_drop ? 0 : int'(fy(m_h, m_w));
               m_e.due = edge_no + LAT + 1;
               q.push_back(m_e);
               if (!m_drop) begin
                  m_eng_h = m_h;
                  m_eng_w = m_w;
               end
               m_ptr = (m_g + 1) % N;
            end
         end
         m_cnt = (m_cnt + 1) % SLOT;
`ifdef PLACE_SCHED_STRIKE_LIMIT_EN
         if (int'(m_strike) >= LIMIT) m_halted = 1;
`endif
         m_strike = eng_strike;
      end
   end

   // Monitor: pops the scoreboard whenever a response is due or presented.
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         if ((q.size() > 0 && q[0].due <= edge_no) || rsp_valid != 0) begin
            if (q.size() == 0) begin
               check("rsp_unexpected", rsp_valid, 0);
            end else begin
               mon_e = q.pop_front();
               check("rsp_valid", rsp_valid, 1 << mon_e.id);
               check("rsp_time", edge_no, mon_e.due);
               check("rsp_drop", rsp_drop, mon_e.drop);
               check("rsp_x", rsp_x, mon_e.x);
               check("rsp_y", rsp_y, mon_e.y);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int c, input int h, input int w);
      req_height[5*c +: 5] = 5'(h);
      req_width[5*c +: 5]  = 5'(w);
   endtask

   task automatic rand_sizes(input bit allow_zero);
      for (int c = 0; c < N; c++) begin
         if (allow_zero && ($urandom % 6 == 0)) set_req(c, 0, $urandom_range(0, 31));
         else set_req(c, $urandom_range(1, 31), $urandom_range(1, 31));
      end
   endtask

   bit found;

   initial begin
      step(3);
      // single request from client 0
      set_req(0, 3, 7);
      req_valid = 4'b0001;
      rst_n = 1'b1;
      step(1);
      req_valid = '0;
      step(16);

      // all clients valid from reset: grants 0,1,2,3,0
      rst_n = 1'b0;
      step(2);
      rand_sizes(0);
      req_valid = 4'b1111;
      rst_n = 1'b1;
      step(5 * SLOT);
      req_valid = '0;
      step(14);

      // zero-height request on client 2
      set_req(2, 0, 5);
      req_valid = 4'b0100;
      step(SLOT);
      req_valid = '0;
      step(14);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom % 3 == 0) begin
            req_valid = N'($urandom);
            rand_sizes(1);
         end
         eng_strike = 4'($urandom_range(0, LIMIT - 1));
         step(1);
      end

      // reset three clocks after a grant
      req_valid = 4'b1111;
      rand_sizes(0);
      found = 0;
      for (int i = 0; i < 2 * SLOT && !found; i++) begin
         if (req_ready != 0) found = 1;
         else step(1);
      end
      check("wait_grant", found, 1);
      step(3);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(6 * SLOT);

      // strike limit
      eng_strike = 4'(LIMIT);
      step(10 * SLOT);
      req_valid = '0;
      eng_strike = '0;
      step(3 * SLOT);
      check("drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/place_req_scheduler.md
# place_req_scheduler

Multi-requester front end for the strip-placement engine (the block that consumes 5-bit height/width and returns 8-bit x/y placement indices plus a 4-bit strike count). It accepts rectangle requests from `NUM_REQ` independent clients over valid/ready handshakes and arbitrates among them round-robin. It issues at most one rectangle per engine slot of `SLOT_CYCLES` clocks and routes each engine result back to the client that owns it after the engine's fixed latency. It sits between the client ports and the engine instance and is the engine's only driver.

## Interface
- `NUM_REQ`, 4, number of requester ports (2..8)
- `SLOT_CYCLES`, 4, clocks per engine issue slot
- `RESULT_LATENCY`, 8, clocks from engine input change to engine output valid
- `STRIKE_LIMIT`, 15, strike count at which issuing stops (used only with the macro)
- `clk_i` in 1: single clock; all state on rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `req_valid_i` in NUM_REQ: per-client request valid
- `req_height_i` in 5*NUM_REQ: packed heights, client i at [5i+4:5i]
- `req_width_i` in 5*NUM_REQ: packed widths, same packing
- `req_ready_o` out NUM_REQ: one-hot accept pulse
- `eng_height_o`, `eng_width_o` out 5 each: engine inputs, registered
- `eng_index_x_i`, `eng_index_y_i` in 8 each: engine placement result
- `eng_strike_i` in 4: engine strike count
- `rsp_valid_o` out NUM_REQ: one-hot, one-cycle response pulse
- `rsp_drop_o` out 1: response belongs to a dropped zero-size request
- `rsp_index_x_o`, `rsp_index_y_o` out 8 each: returned placement
- `strike_o` out 4: registered copy of `eng_strike_i`
- `busy_o` out 1: any request is in flight
- `halted_o` out 1: issuing stopped on strike limit

## Operation
- Slot counter runs 0..SLOT_CYCLES-1 and wraps. A slot start is an edge at which the counter is 0.
- At each slot start, the arbiter grants the first valid client at or above the RR pointer, wrapping upward. `req_ready_o[g]` is high in the cycle before that edge, so the handshake completes on it. The pointer then moves to (g+1) mod NUM_REQ. With no grant, the pointer is unchanged.
- Requests with a nonzero height and width: `eng_height_o`/`eng_width_o` take the values at the grant edge and hold them for the full slot.
- Zero-size requests (height==0 or width==0) are accepted but not issued. The engine receives 0/0 for that slot, and the response carries `rsp_drop_o`=1 with x=y=0.
- Empty slot: the engine receives 0/0 (bubble).
- A tag delay line of RESULT_LATENCY+1 stages carries {valid, drop, client id}.
- At grant edge G+RESULT_LATENCY+1, the block registers the engine indices (or zeros for a drop) into `rsp_index_*_o` and pulses `rsp_valid_o[id]` for one cycle. The index outputs hold until the next response.
- `busy_o` = any tag stage valid.

## Timing
- Reset values: all outputs 0; slot counter 0; RR pointer 0; tags invalid.
- The first rising edge after `rst_ni` deasserts is a slot start.
- Reset asserted mid-operation discards in-flight tags with no response, and `eng_*_o` return to 0 immediately.
- Issue throughput is at most one request per SLOT_CYCLES clocks.
- Latency from accept to response is RESULT_LATENCY+1 clocks.
- `strike_o` is `eng_strike_i` delayed by one register.
- `req_ready_o` is never high outside the cycle preceding a slot start.
- A client that drops valid before its grant is simply skipped; valid may change freely.

## Configuration
- `PLACE_SCHED_STRIKE_LIMIT_EN` defined: once the registered `strike_o` >= STRIKE_LIMIT, `halted_o` goes to 1. After that, every slot is a bubble and `req_ready_o` stays 0 until reset. In-flight tags still complete.
- Not defined: `halted_o` is tied 0 and issuing never stops.

## Structure
- `place_sched_pkg` holds:
  - widths HEIGHT_W=5, WIDTH_W=5, IDX_W=8, STRIKE_W=4
  - max NUM_REQ
  - the packed tag struct {valid, drop, id}
- Sub-module `place_sched_rr_arb` is the combinational masked round-robin grant plus the registered pointer update. The top holds the slot counter, engine registers, tag line and response registers.

## Test plan
- Reset, client 0 sends h=3,w=7 → `eng_height_o`=3, `eng_width_o`=7 from the grant edge; `rsp_valid_o`=0001 exactly 9 clocks after accept, carrying the engine's x/y.
- All four clients hold valid from reset → grants in order 0,1,2,3,0 on consecutive slot starts, 4 clocks apart; responses return in the same order.
- Client 2 sends h=0,w=5 → accepted, engine sees 0/0 for that slot, response pulse on bit 2 with `rsp_drop_o`=1, x=y=0.
- `rst_ni` pulsed low 3 clocks after a grant → no response ever appears, `busy_o`=0, and the next grant goes to client 0.
- With the macro, engine strike rises to 15 → `halted_o`=1 two edges later, no further `req_ready_o`, and pending responses still delivered. Without the macro, issuing continues.
